// File: rtl/me_frame_scheduler.sv
// Frame sequencer for the motion-estimation core: walks macroblocks in
// raster order, loads, runs one search, and emits one result per block.
module me_frame_scheduler #(
  parameter int MB_COLS = 4,
  parameter int MB_ROWS = 3,
  parameter int TIMEOUT = 4200,
  parameter int SUM_W   = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             load_req,
  input  logic             load_ack,
  output logic [7:0]       mb_x,
  output logic [7:0]       mb_y,
  output logic             me_start,
  input  logic             me_completed,
  input  logic [7:0]       best_dist,
  input  logic [3:0]       motion_x,
  input  logic [3:0]       motion_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_dist,
  output logic [3:0]       res_vx,
  output logic [3:0]       res_vy,
  output logic [7:0]       res_mb_x,
  output logic [7:0]       res_mb_y,
  output logic [SUM_W-1:0] sad_sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [7:0] LAST_X = 8'(MB_COLS - 1);
  localparam logic [7:0] LAST_Y = 8'(MB_ROWS - 1);

  state_t state;
  state_t state_next;

  logic [WD_W-1:0] wdog;
  logic            wd_hit;
  logic            last_mb;
  logic            accept;
  logic [SUM_W:0]  sum_ext;

  assign wd_hit  = (wdog == WD_LAST);
  assign last_mb = (mb_x == LAST_X) && (mb_y == LAST_Y);
  assign accept  = (state == S_EMIT) && res_ready;
  assign sum_ext = {1'b0, sad_sum} + (SUM_W + 1)'(best_dist);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (frame_start) state_next = S_LOAD;
      S_LOAD: if (load_ack) state_next = S_RUN;
      S_RUN: begin
        // completion on the last allowed cycle still wins over abort
        if (me_completed)  state_next = S_EMIT;
        else if (wd_hit)   state_next = S_IDLE;
      end
      S_EMIT: begin
        if (res_ready) state_next = last_mb ? S_DONE : S_LOAD;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_req   = 1'b0;
    me_start   = 1'b0;
    res_valid  = 1'b0;
    frame_done = 1'b0;
    frame_busy = 1'b0;
    unique case (state)
      S_LOAD: begin
        load_req   = 1'b1;
        frame_busy = 1'b1;
      end
      S_RUN: begin
        me_start   = 1'b1;
        frame_busy = 1'b1;
      end
      S_EMIT: begin
        res_valid  = 1'b1;
        frame_busy = 1'b1;
      end
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mb_x        <= '0;
      mb_y        <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
      sad_sum     <= '0;
      res_dist    <= '0;
      res_vx      <= '0;
      res_vy      <= '0;
      res_mb_x    <= '0;
      res_mb_y    <= '0;
    end else begin
      if (state == S_IDLE && frame_start) begin
        mb_x        <= '0;
        mb_y        <= '0;
        sad_sum     <= '0;
        err_timeout <= 1'b0;
      end
      if (state == S_LOAD && load_ack) wdog <= '0;
      if (state == S_RUN) begin
        wdog <= wdog + 1'b1;
        if (me_completed) begin
          res_dist <= best_dist;
          res_vx   <= motion_x;
          res_vy   <= motion_y;
          res_mb_x <= mb_x;
          res_mb_y <= mb_y;
          if (sum_ext[SUM_W]) sad_sum <= '1;
          else                sad_sum <= sum_ext[SUM_W-1:0];
        end else if (wd_hit) begin
          err_timeout <= 1'b1;
        end
      end
      if (accept && !last_mb) begin
        if (mb_x == LAST_X) begin
          mb_x <= '0;
          mb_y <= mb_y + 8'd1;
        end else begin
          mb_x <= mb_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Randomized bench for me_frame_scheduler with a frame-level
// reference model checked against every output on every cycle.
module tb_me_frame_scheduler;

  localparam int MBC = 3;
  localparam int MBR = 2;
  localparam int NMB = MBC * MBR;
  localparam int TO  = 4200;
  localparam int SW  = 10;
  localparam int SMAX = (1 << SW) - 1;
  localparam int LNOM = 4112;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_busy, frame_done, err_timeout;
  logic          load_req;
  logic          load_ack = 1'b0;
  logic [7:0]    mb_x, mb_y;
  logic          me_start;
  logic          me_completed = 1'b0;
  logic [7:0]    best_dist = '0;
  logic [3:0]    motion_x = '0;
  logic [3:0]    motion_y = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_dist;
  logic [3:0]    res_vx, res_vy;
  logic [7:0]    res_mb_x, res_mb_y;
  logic [SW-1:0] sad_sum;

  me_frame_scheduler #(
    .MB_COLS(MBC), .MB_ROWS(MBR), .TIMEOUT(TO), .SUM_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .load_req(load_req),
    .load_ack(load_ack), .mb_x(mb_x), .mb_y(mb_y),
    .me_start(me_start), .me_completed(me_completed),
    .best_dist(best_dist), .motion_x(motion_x),
    .motion_y(motion_y), .res_valid(res_valid),
    .res_ready(res_ready), .res_dist(res_dist),
    .res_vx(res_vx), .res_vy(res_vy), .res_mb_x(res_mb_x),
    .res_mb_y(res_mb_y), .sad_sum(sad_sum)
  );

  always #5 clock = ~clock;

  // phase: 0 idle, 1 loading, 2 searching, 3 result held, 4 done
  int m_ph = 0, m_idx = 0, m_wd = 0, m_sum = 0, m_err = 0;
  int m_rd = 0, m_rvx = 0, m_rvy = 0, m_rmx = 0, m_rmy = 0;

  int  n_chk = 0, n_fail = 0;
  int  lat = 5, ack_dly = 3, bp_len = 0;
  bit  never = 0, spur = 0, rnd_ready = 0, fs_req = 0;
  int  ld_wait = 0, bp_cnt = 0;
  int  dq[NMB], vxq[NMB], vyq[NMB];
  int  run_cyc, acc_cnt, done_cnt;
  int  acc_x[$], acc_y[$], acc_s[$];

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endfunction

  task automatic model_update();
    if (reset) begin
      m_ph = 0; m_idx = 0; m_wd = 0; m_sum = 0; m_err = 0;
      m_rd = 0; m_rvx = 0; m_rvy = 0; m_rmx = 0; m_rmy = 0;
    end else begin
      case (m_ph)
        0: if (frame_start) begin
          m_ph = 1; m_idx = 0; m_sum = 0; m_err = 0;
        end
        1: if (load_ack) begin
          m_ph = 2; m_wd = 0;
        end
        2: begin
          m_wd++;
          if (me_completed) begin
            m_rd = best_dist; m_rvx = motion_x; m_rvy = motion_y;
            m_rmx = m_idx % MBC; m_rmy = m_idx / MBC;
            m_sum = (m_sum + m_rd > SMAX) ? SMAX : m_sum + m_rd;
            m_ph = 3;
          end else if (m_wd == TO) begin
            m_err = 1; m_ph = 0;
          end
        end
        3: if (res_ready) begin
          if (m_idx == NMB - 1) m_ph = 4;
          else begin m_idx++; m_ph = 1; end
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic compare();
    logic [63:0] e, a;
    e = {m_ph inside {1, 2, 3}, m_ph == 4, m_err != 0, m_ph == 1,
         8'(m_idx % MBC), 8'(m_idx / MBC), m_ph == 2, m_ph == 3,
         8'(m_rd), 4'(m_rvx), 4'(m_rvy), 8'(m_rmx), 8'(m_rmy),
         10'(m_sum)};
    a = {frame_busy, frame_done, err_timeout, load_req, mb_x, mb_y,
         me_start, res_valid, res_dist, res_vx, res_vy, res_mb_x,
         res_mb_y, sad_sum};
    check("outputs", a, e);
    if (me_start) run_cyc++;
    if (frame_done) done_cnt++;
  endtask

  task automatic drive();
    frame_start = fs_req || (spur && m_ph != 0 &&
                             $urandom_range(0, 19) == 0);
    fs_req = 0;
    if (m_ph == 1) begin
      load_ack = (ld_wait >= ack_dly);
      ld_wait++;
    end else begin
      ld_wait = 0;
      load_ack = spur && $urandom_range(0, 24) == 0;
    end
    best_dist = 8'($urandom);
    motion_x = 4'($urandom);
    motion_y = 4'($urandom);
    me_completed = 1'b0;
    if (m_ph == 2 && !never && m_wd >= lat - 1) begin
      me_completed = 1'b1;
      best_dist = 8'(dq[m_idx]);
      motion_x = 4'(vxq[m_idx]);
      motion_y = 4'(vyq[m_idx]);
    end else if (m_ph == 1 && spur && $urandom_range(0, 3) == 0) begin
      me_completed = 1'b1;
    end
    if (m_ph == 3) begin
      if (bp_cnt < bp_len) begin
        res_ready = 1'b0;
        bp_cnt++;
      end else begin
        res_ready = rnd_ready ? 1'($urandom) : 1'b1;
      end
    end else begin
      bp_cnt = 0;
      res_ready = spur ? 1'($urandom) : 1'b0;
    end
    if (res_valid && res_ready) begin
      acc_cnt++;
      acc_x.push_back(int'(res_mb_x));
      acc_y.push_back(int'(res_mb_y));
      acc_s.push_back(int'(sad_sum));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare();
    drive();
  endtask

  task automatic clear_stats();
    run_cyc = 0; acc_cnt = 0; done_cnt = 0;
    acc_x.delete(); acc_y.delete(); acc_s.delete();
  endtask

  task automatic run_frame(input int budget);
    bit started;
    int cyc;
    started = 0;
    cyc = 0;
    clear_stats();
    fs_req = 1;
    while (1) begin
      tick();
      cyc++;
      if (m_ph != 0) started = 1;
      if (started && m_ph == 0) break;
      if (cyc > budget) begin
        check("frame_budget", 64'(cyc), 64'(budget));
        break;
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NMB; i++) begin
      dq[i] = $urandom_range(0, 255);
      vxq[i] = $urandom_range(0, 15);
      vyq[i] = $urandom_range(0, 15);
    end
  endtask

  int xs[NMB] = '{0, 1, 2, 0, 1, 2};
  int ys[NMB] = '{0, 0, 0, 1, 1, 1};
  int sat[NMB] = '{255, 510, 765, 1020, 1023, 1023};

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 64'(frame_busy), 64'd0);
    check("rst_sum", 64'(sad_sum), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);

    // nominal frame with full-length searches
    lat = LNOM; ack_dly = 3;
    dq = '{10, 20, 30, 40, 50, 60};
    vxq = '{1, 2, 3, 4, 5, 6};
    vyq = '{9, 8, 7, 6, 5, 4};
    run_frame(30000);
    check("nom_run_cycles", 64'(run_cyc), 64'(NMB * LNOM));
    check("nom_results", 64'(acc_cnt), 64'd6);
    check("nom_done", 64'(done_cnt), 64'd1);
    check("nom_sum", 64'(sad_sum), 64'd210);
    check("nom_busy", 64'(frame_busy), 64'd0);
    for (int k = 0; k < acc_x.size(); k++) begin
      check("nom_x", 64'(acc_x[k]), 64'(xs[k]));
      check("nom_y", 64'(acc_y[k]), 64'(ys[k]));
    end

    // backpressure and saturation
    lat = 5; bp_len = 10;
    foreach (dq[i]) dq[i] = 255;
    run_frame(2000);
    check("sat_results", 64'(acc_cnt), 64'd6);
    for (int k = 0; k < acc_s.size(); k++)
      check("sat_sum", 64'(acc_s[k]), 64'(sat[k]));
    check("sat_final", 64'(sad_sum), 64'd1023);

    // watchdog abort
    never = 1; bp_len = 0;
    run_frame(6000);
    check("wd_run_cycles", 64'(run_cyc), 64'(TO));
    check("wd_err", 64'(err_timeout), 64'd1);
    check("wd_results", 64'(acc_cnt), 64'd0);
    check("wd_done", 64'(done_cnt), 64'd0);
    check("wd_busy", 64'(frame_busy), 64'd0);
    never = 0;

    // new frame clears the error; spurious inputs mixed in
    spur = 1; rnd_ready = 1; bp_len = 2; lat = 7; ack_dly = 1;
    rand_data();
    run_frame(3000);
    check("clr_err", 64'(err_timeout), 64'd0);
    check("spur_results", 64'(acc_cnt), 64'd6);
    check("spur_done", 64'(done_cnt), 64'd1);

    // reset in the middle of a long search
    spur = 0; lat = LNOM;
    clear_stats();
    fs_req = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_ph == 2 && m_wd == 2000) break;
    end
    check("mid_reached", 64'(m_wd), 64'd2000);
    reset = 1'b1;
    tick();
    check("mid_busy", 64'(frame_busy), 64'd0);
    check("mid_start", 64'(me_start), 64'd0);
    check("mid_sum", 64'(sad_sum), 64'd0);
    check("mid_dist", 64'(res_dist), 64'd0);
    reset = 1'b0;
    tick();
    lat = 3;
    rand_data();
    run_frame(3000);
    if (acc_x.size() > 0) begin
      check("restart_x", 64'(acc_x[0]), 64'd0);
      check("restart_y", 64'(acc_y[0]), 64'd0);
    end
    check("restart_results", 64'(acc_cnt), 64'd6);

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      spur = 1'($urandom);
      rnd_ready = 1'($urandom);
      lat = $urandom_range(1, 40);
      ack_dly = $urandom_range(0, 4);
      bp_len = $urandom_range(0, 3);
      rand_data();
      run_frame(4000);
      check("rnd_results", 64'(acc_cnt), 64'd6);
      check("rnd_done", 64'(done_cnt), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
